// File: rtl/modexp_wb_bridge_pkg.sv
// rtl/modexp_wb_bridge_pkg.sv - shared types, defaults and window decode for the modexp Wishbone bridge
package modexp_wb_bridge_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        FWD      = 2'd1,
        RESP_ACK = 2'd2,
        RESP_ERR = 2'd3
    } state_t;

    localparam logic [31:0] DEF_BASE_ADDR   = 32'h0000_0000;
    localparam logic [31:0] DEF_WINDOW_SIZE = 32'h0000_1000;
    localparam int          DEF_TIMEOUT     = 256;
    localparam int          DEF_CNT_W       = 16;

    // Modulo subtract keeps the test a single compare for any non-wrapping window.
    function automatic logic in_window(input logic [31:0] adr,
                                       input logic [31:0] base,
                                       input logic [31:0] size);
        return (adr - base) < size;
    endfunction

endpackage

// File: rtl/modexp_wb_timeout.sv
// rtl/modexp_wb_timeout.sv - access watchdog, pulses expired on the last allowed wait cycle
module modexp_wb_timeout
    import modexp_wb_bridge_pkg::*;
#(
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic clk,
    input  logic clear_i,
    input  logic enable_i,
    output logic expired_o
);

    localparam int CW = $clog2(TIMEOUT);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (enable_i) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        cnt_q <= cnt_d;
    end

    assign expired_o = enable_i && !clear_i && (cnt_q == CW'(TIMEOUT - 1));

endmodule

// File: rtl/modexp_wb_bridge.sv
// rtl/modexp_wb_bridge.sv - registered Wishbone classic bridge from the NA master to the modexp accelerator
module modexp_wb_bridge
    import modexp_wb_bridge_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR   = DEF_BASE_ADDR,
    parameter logic [31:0] WINDOW_SIZE = DEF_WINDOW_SIZE,
    parameter int          TIMEOUT     = DEF_TIMEOUT,
    parameter int          CNT_W       = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [31:0]      s_adr_i,
    input  logic [31:0]      s_dat_i,
    input  logic [3:0]       s_sel_i,
    input  logic             s_we_i,
    input  logic             s_cyc_i,
    input  logic             s_stb_i,
    output logic             s_ack_o,
    output logic             s_err_o,
    output logic [31:0]      s_dat_o,
    output logic [31:0]      m_adr_o,
    output logic [31:0]      m_dat_o,
    output logic [3:0]       m_sel_o,
    output logic             m_we_o,
    output logic             m_cyc_o,
    output logic             m_stb_o,
    input  logic             m_ack_i,
    input  logic             m_err_i,
    input  logic [31:0]      m_dat_i,
    output logic [CNT_W-1:0] timeout_cnt,
    output logic [CNT_W-1:0] decode_err_cnt
);

    state_t           state_q;
    logic [31:0]      adr_q;
    logic [31:0]      wdat_q;
    logic [3:0]       sel_q;
    logic             we_q;
    logic             m_cyc_q;
    logic             s_ack_q;
    logic             s_err_q;
    logic [31:0]      rdat_q;
    logic [CNT_W-1:0] to_cnt_q;
    logic [CNT_W-1:0] de_cnt_q;
    logic             expired;

    modexp_wb_timeout #(.TIMEOUT(TIMEOUT)) u_timeout (
        .clk       (clk),
        .clear_i   (rst || (state_q != FWD)),
        .enable_i  (state_q == FWD),
        .expired_o (expired)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            adr_q    <= '0;
            wdat_q   <= '0;
            sel_q    <= '0;
            we_q     <= 1'b0;
            m_cyc_q  <= 1'b0;
            s_ack_q  <= 1'b0;
            s_err_q  <= 1'b0;
            rdat_q   <= '0;
            to_cnt_q <= '0;
            de_cnt_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    s_ack_q <= 1'b0;
                    s_err_q <= 1'b0;
                    if (s_cyc_i && s_stb_i) begin
                        if (in_window(s_adr_i, BASE_ADDR, WINDOW_SIZE)) begin
                            adr_q   <= s_adr_i - BASE_ADDR;
                            wdat_q  <= s_dat_i;
                            sel_q   <= s_sel_i;
                            we_q    <= s_we_i;
                            m_cyc_q <= 1'b1;
                            state_q <= FWD;
                        end else begin
                            s_err_q <= 1'b1;
                            state_q <= RESP_ERR;
                            if (de_cnt_q != '1) de_cnt_q <= de_cnt_q + CNT_W'(1);
                        end
                    end
                end
                FWD: begin
                    // Abort outranks any accelerator response so a dropped cycle never sees an ack.
                    if (!s_cyc_i) begin
                        m_cyc_q <= 1'b0;
                        state_q <= IDLE;
                    end else if (m_err_i) begin
                        m_cyc_q <= 1'b0;
                        s_err_q <= 1'b1;
                        state_q <= RESP_ERR;
                    end else if (m_ack_i) begin
                        m_cyc_q <= 1'b0;
                        s_ack_q <= 1'b1;
                        if (!we_q) rdat_q <= m_dat_i;
                        state_q <= RESP_ACK;
                    end else if (expired) begin
                        m_cyc_q <= 1'b0;
                        s_err_q <= 1'b1;
                        state_q <= RESP_ERR;
                        if (to_cnt_q != '1) to_cnt_q <= to_cnt_q + CNT_W'(1);
                    end
                end
                default: begin
                    s_ack_q <= 1'b0;
                    s_err_q <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign s_ack_o        = s_ack_q;
    assign s_err_o        = s_err_q;
    assign s_dat_o        = rdat_q;
    assign m_adr_o        = adr_q;
    assign m_dat_o        = wdat_q;
    assign m_sel_o        = sel_q;
    assign m_we_o         = we_q;
    assign m_cyc_o        = m_cyc_q;
    assign m_stb_o        = m_cyc_q;
    assign timeout_cnt    = to_cnt_q;
    assign decode_err_cnt = de_cnt_q;

endmodule

// File: tb/tb_modexp_wb_bridge.sv
// tb/tb_modexp_wb_bridge.sv - randomized self-checking bench for modexp_wb_bridge
module tb_modexp_wb_bridge;

    localparam logic [31:0] BASE = 32'h0001_0000;
    localparam logic [31:0] WIN  = 32'h0000_1000;
    localparam int          TO   = 8;
    localparam int          CW   = 3;
    localparam int          SAT  = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst;
    logic [31:0]   s_adr, s_dat, m_dat;
    logic [3:0]    s_sel;
    logic          s_we, s_cyc, s_stb, m_ack, m_err;
    logic          s_ack_o, s_err_o, m_we_o, m_cyc_o, m_stb_o;
    logic [31:0]   s_dat_o, m_adr_o, m_dat_o;
    logic [3:0]    m_sel_o;
    logic [CW-1:0] timeout_cnt, decode_err_cnt;

    int          n_cmp = 0;
    int          n_fail = 0;
    logic [31:0] exp_dat;
    int          exp_to;
    int          exp_de;

    always #5 clk = ~clk;

    modexp_wb_bridge #(
        .BASE_ADDR(BASE), .WINDOW_SIZE(WIN), .TIMEOUT(TO), .CNT_W(CW)
    ) dut (
        .clk(clk), .rst(rst),
        .s_adr_i(s_adr), .s_dat_i(s_dat), .s_sel_i(s_sel), .s_we_i(s_we),
        .s_cyc_i(s_cyc), .s_stb_i(s_stb), .s_ack_o(s_ack_o), .s_err_o(s_err_o),
        .s_dat_o(s_dat_o), .m_adr_o(m_adr_o), .m_dat_o(m_dat_o), .m_sel_o(m_sel_o),
        .m_we_o(m_we_o), .m_cyc_o(m_cyc_o), .m_stb_o(m_stb_o),
        .m_ack_i(m_ack), .m_err_i(m_err), .m_dat_i(m_dat),
        .timeout_cnt(timeout_cnt), .decode_err_cnt(decode_err_cnt)
    );

    // kind: 0 ack, 1 err, 2 ack+err, 3 never respond; response comes after wait_n stall cycles
    task automatic access(input logic [31:0] adr, input logic [31:0] dat, input logic [3:0] sel,
                          input logic we, input int wait_n, input int kind, input logic [31:0] rdata);
        logic inwin, exp_err, done;
        int   exp_stb, stb_n, resp_idx;
        inwin = (adr >= BASE) && (adr < BASE + WIN);
        if (inwin) begin
            if (kind != 3 && wait_n < TO) begin
                exp_stb = wait_n + 1;
                exp_err = (kind != 0);
            end else begin
                exp_stb = TO;
                exp_err = 1'b1;
                exp_to  = (exp_to < SAT) ? exp_to + 1 : SAT;
            end
            if (!exp_err && !we) exp_dat = rdata;
        end else begin
            exp_stb = 0;
            exp_err = 1'b1;
            exp_de  = (exp_de < SAT) ? exp_de + 1 : SAT;
        end
        @(posedge clk); #1;
        s_adr = adr; s_dat = dat; s_sel = sel; s_we = we; s_cyc = 1'b1; s_stb = 1'b1;
        stb_n = 0; done = 1'b0; resp_idx = 0;
        for (int idx = 1; idx <= 40 && !done; idx++) begin
            @(posedge clk); #1;
            if (s_ack_o || s_err_o) begin
                done = 1'b1;
                resp_idx = idx;
                s_cyc = 1'b0; s_stb = 1'b0; m_ack = 1'b0; m_err = 1'b0;
            end else if (m_stb_o) begin
                stb_n++;
                if (stb_n == 1) begin
                    n_cmp++;
                    if ({m_adr_o, m_dat_o, m_sel_o, m_we_o, m_cyc_o} !== {adr - BASE, dat, sel, we, 1'b1}) begin
                        n_fail++;
                        $display("FAIL fwd_req adr=%h: got adr=%h dat=%h sel=%h we=%b cyc=%b, want adr=%h dat=%h sel=%h we=%b cyc=1",
                                 adr, m_adr_o, m_dat_o, m_sel_o, m_we_o, m_cyc_o, adr - BASE, dat, sel, we);
                    end
                end
                if (kind != 3 && stb_n == wait_n + 1) begin
                    m_ack = (kind != 1); m_err = (kind != 0); m_dat = rdata;
                end else begin
                    m_ack = 1'b0; m_err = 1'b0; m_dat = $urandom;
                end
            end else begin
                m_ack = 1'b0; m_err = 1'b0;
            end
        end
        n_cmp++;
        if (!done) begin
            n_fail++;
            $display("FAIL resp_wait adr=%h: no s_ack_o/s_err_o within 40 cycles", adr);
            s_cyc = 1'b0; s_stb = 1'b0; m_ack = 1'b0; m_err = 1'b0;
        end else begin
            n_cmp++;
            if ({s_ack_o, s_err_o} !== {~exp_err, exp_err}) begin
                n_fail++;
                $display("FAIL resp_kind adr=%h: got ack=%b err=%b want ack=%b err=%b",
                         adr, s_ack_o, s_err_o, ~exp_err, exp_err);
            end
            n_cmp++;
            if (stb_n !== exp_stb || resp_idx !== exp_stb + 1) begin
                n_fail++;
                $display("FAIL resp_timing adr=%h: got stb_cycles=%0d resp_cycle=%0d want %0d/%0d",
                         adr, stb_n, resp_idx, exp_stb, exp_stb + 1);
            end
            n_cmp++;
            if ({m_cyc_o, m_stb_o} !== 2'b00 || s_dat_o !== exp_dat) begin
                n_fail++;
                $display("FAIL resp_data adr=%h: got cyc=%b stb=%b s_dat=%h want cyc=0 stb=0 s_dat=%h",
                         adr, m_cyc_o, m_stb_o, s_dat_o, exp_dat);
            end
            n_cmp++;
            if (int'(timeout_cnt) !== exp_to || int'(decode_err_cnt) !== exp_de) begin
                n_fail++;
                $display("FAIL counters adr=%h: got to=%0d de=%0d want to=%0d de=%0d",
                         adr, timeout_cnt, decode_err_cnt, exp_to, exp_de);
            end
        end
        @(posedge clk); #1;
        n_cmp++;
        if ({s_ack_o, s_err_o, m_cyc_o} !== 3'b000) begin
            n_fail++;
            $display("FAIL resp_pulse adr=%h: got ack=%b err=%b cyc=%b one cycle later, want 0/0/0",
                     adr, s_ack_o, s_err_o, m_cyc_o);
        end
    endtask

    task automatic check_all_zero(input string name);
        n_cmp++;
        if ({s_ack_o, s_err_o, s_dat_o, m_adr_o, m_dat_o, m_sel_o, m_we_o, m_cyc_o, m_stb_o,
             timeout_cnt, decode_err_cnt} !== '0) begin
            n_fail++;
            $display("FAIL %s: outputs not all zero ack=%b err=%b sdat=%h madr=%h mdat=%h sel=%h we=%b cyc=%b stb=%b to=%0d de=%0d",
                     name, s_ack_o, s_err_o, s_dat_o, m_adr_o, m_dat_o, m_sel_o, m_we_o, m_cyc_o, m_stb_o,
                     timeout_cnt, decode_err_cnt);
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        s_adr = '0; s_dat = '0; s_sel = '0; s_we = 1'b0; s_cyc = 1'b0; s_stb = 1'b0;
        m_ack = 1'b0; m_err = 1'b0; m_dat = '0;
        exp_dat = '0; exp_to = 0; exp_de = 0;
        repeat (3) @(posedge clk);
        #1;
        check_all_zero("reset_state");
        rst = 1'b0;
    endtask

    task automatic test_write;
        access(BASE + 32'h10, 32'hDEAD_BEEF, 4'hF, 1'b1, 2, 0, 32'hCAFE_F00D);
    endtask

    task automatic test_read;
        access(BASE + 32'h20, 32'h0, 4'hF, 1'b0, 0, 0, 32'h1234_5678);
    endtask

    task automatic test_decode;
        access(32'h0000_2000,   32'h1, 4'h1, 1'b0, 0, 0, 32'h1);
        access(BASE + WIN,      32'h2, 4'h3, 1'b1, 0, 0, 32'h2);
        access(BASE - 32'h4,    32'h3, 4'hF, 1'b0, 0, 0, 32'h3);
        access(BASE + WIN - 1,  32'h4, 4'h8, 1'b0, 1, 0, 32'hA5A5_0001);
        access(BASE,            32'h5, 4'hF, 1'b0, 0, 0, 32'hA5A5_0002);
    endtask

    task automatic test_timeout;
        access(BASE + 32'h4, 32'h77, 4'hF, 1'b1, 0, 3, 32'h0);
        access(BASE + 32'h8, 32'h0, 4'hF, 1'b0, TO, 0, 32'h5555_AAAA);
    endtask

    task automatic test_ack_at_expiry;
        access(BASE + 32'h30, 32'h0, 4'hF, 1'b0, TO - 1, 0, 32'h0BAD_CAFE);
        access(BASE + 32'h34, 32'h0, 4'hF, 1'b0, TO - 1, 2, 32'h1111_2222);
        access(BASE + 32'h38, 32'h0, 4'hF, 1'b0, 0, 2, 32'h3333_4444);
        access(BASE + 32'h3C, 32'h9, 4'hF, 1'b1, 3, 1, 32'h5555_6666);
    endtask

    task automatic test_abort;
        int  stb_n;
        logic seen;
        @(posedge clk); #1;
        s_adr = BASE + 32'h40; s_dat = 32'h99; s_sel = 4'hF; s_we = 1'b1; s_cyc = 1'b1; s_stb = 1'b1;
        stb_n = 0;
        for (int k = 0; k < 20 && stb_n < 3; k++) begin
            @(posedge clk); #1;
            if (m_stb_o) stb_n++;
        end
        n_cmp++;
        if (stb_n !== 3) begin
            n_fail++;
            $display("FAIL abort_fwd: got %0d strobe cycles want 3", stb_n);
        end
        s_cyc = 1'b0; s_stb = 1'b0;
        @(posedge clk); #1;
        n_cmp++;
        if ({m_cyc_o, m_stb_o} !== 2'b00) begin
            n_fail++;
            $display("FAIL abort_drop: got cyc=%b stb=%b want 0/0", m_cyc_o, m_stb_o);
        end
        seen = 1'b0;
        repeat (12) begin
            @(posedge clk); #1;
            if (s_ack_o || s_err_o || m_cyc_o) seen = 1'b1;
        end
        n_cmp++;
        if (seen !== 1'b0 || int'(timeout_cnt) !== exp_to || int'(decode_err_cnt) !== exp_de) begin
            n_fail++;
            $display("FAIL abort_quiet: got activity=%b to=%0d de=%0d want 0/%0d/%0d",
                     seen, timeout_cnt, decode_err_cnt, exp_to, exp_de);
        end

        @(posedge clk); #1;
        s_adr = BASE + 32'h44; s_we = 1'b0; s_cyc = 1'b1; s_stb = 1'b1;
        stb_n = 0;
        for (int k = 0; k < 20 && stb_n < 2; k++) begin
            @(posedge clk); #1;
            if (m_stb_o) stb_n++;
        end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; s_cyc = 1'b0; s_stb = 1'b0;
        exp_dat = '0; exp_to = 0; exp_de = 0;
        check_all_zero("reset_mid_fwd");
        seen = 1'b0;
        repeat (10) begin
            @(posedge clk); #1;
            if (s_ack_o || s_err_o || m_cyc_o) seen = 1'b1;
        end
        n_cmp++;
        if (seen !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_quiet: got activity=%b want 0", seen);
        end
        access(BASE + 32'h48, 32'h0, 4'hF, 1'b0, 1, 0, 32'hFEED_0001);
    endtask

    task automatic test_saturation;
        for (int i = 0; i < SAT + 2; i++)
            access(32'hF000_0000 + 32'(i * 4), 32'h0, 4'hF, 1'b0, 0, 0, 32'h0);
        for (int i = 0; i < SAT + 2; i++)
            access(BASE + 32'(i * 4), 32'h0, 4'hF, 1'b1, 0, 3, 32'h0);
    endtask

    task automatic test_random;
        logic [31:0] adr;
        for (int i = 0; i < 40; i++) begin
            case ($urandom_range(0, 5))
                0:       adr = $urandom;
                1:       adr = BASE + WIN + 32'($urandom_range(0, 3));
                2:       adr = BASE - 32'd1 - 32'($urandom_range(0, 3));
                default: adr = BASE + ($urandom & (WIN - 1));
            endcase
            access(adr, $urandom, 4'($urandom), 1'($urandom), $urandom_range(0, 9),
                   $urandom_range(0, 3), $urandom);
        end
    endtask

    initial begin
        test_reset;
        test_write;
        test_read;
        test_decode;
        test_timeout;
        test_ack_at_expiry;
        test_abort;
        test_saturation;
        test_reset;
        test_random;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
